serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial add controller: time-multiplexes one FullAdder instance over DATA_WIDTH cycles. Replaces the DATA_WIDTH parallel adders of a ripple adder with a single one.
- Sits between a valid/ready operand source and a valid/ready result sink.
- Owns the operand shift registers, the carry flop, the bit counter and the sequencing FSM.
- Trades throughput for area: one add per DATA_WIDTH+2 cycles.

Parameters:
DATA_WIDTH, 4, operand/sum width in bits; legal range 2..32.
CNT_WIDTH, 5, width of the bit counter; must satisfy 2**CNT_WIDTH >= DATA_WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset, synchronous, active-low.
in_a  input  DATA_WIDTH  operand a, unsigned.
in_b  input  DATA_WIDTH  operand b, unsigned.
in_ci  input  1  carry-in.
in_vld  input  1  operands valid.
in_rd  output  1  controller ready to accept operands.
out_s  output  DATA_WIDTH  sum.
out_co  output  1  carry-out.
out_vld  output  1  result valid.
out_rd  input  1  sink ready.
busy  output  1  high in RUN and DONE.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). No other clock or reset.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, counter=0, carry=0, shift registers=0.
  - Outputs: in_rd=1, out_vld=0, busy=0, out_s=0, out_co=0.
- FSM states: IDLE, RUN, DONE. Registered (Moore) outputs only; no combinational path from in_vld or out_rd to any output.
- IDLE:
  - in_rd=1.
  - On in_vld=1: load a_sh<=in_a, b_sh<=in_b, carry<=in_ci, s_sh<=0, cnt<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - in_rd=0; in_vld is ignored and operands are not captured.
  - FullAdder inputs: a=a_sh[0], b=b_sh[0], ci=carry.
  - Each cycle: carry<=fa.co; a_sh and b_sh shift right by 1 with 0 filled at the MSB; s_sh shifts right by 1 with fa.s entering at bit DATA_WIDTH-1; cnt<=cnt+1.
  - When cnt==DATA_WIDTH-1, after this final bit: go to DONE.
- DONE:
  - out_vld=1, out_s=s_sh, out_co=carry.
  - All three are held stable until out_rd=1.
  - On out_rd=1: go to IDLE. No new operands are accepted in this same cycle.
- Latency: handshake on edge E0 gives out_vld=1 after edge E(DATA_WIDTH), which is 5 edges after the handshake cycle for DATA_WIDTH=4.
- Throughput: back-to-back issue at 1 op per DATA_WIDTH+2 cycles when out_rd is tied high.
- Arithmetic: {out_co,out_s} = in_a + in_b + in_ci, modulo 2**(DATA_WIDTH+1). This is exact.
- out_s and out_co keep their last DONE value while in IDLE and RUN; they are qualified only by out_vld.
- Boundaries:
  - Reset mid-RUN or mid-DONE aborts the operation; the result is lost and out_vld drops at that edge.
  - out_rd=1 outside DONE has no effect.
  - All-ones operands with in_ci=1 give out_s=all-ones, out_co=1; the counter does not wrap.
  - cnt never exceeds DATA_WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADDER_CTRL_OVF_EN.
- Defined:
  - Adds output port out_ovf (1 bit): signed two's-complement overflow.
  - out_ovf = carry into the MSB XOR carry out of the MSB, captured on the last RUN cycle.
  - Reset value 0. Valid under the same out_vld qualification and held the same way as out_s.
- Undefined: the out_ovf port and its flop do not exist; all other behaviour is identical.

Test Plan:
- Reset then in_a=3, in_b=5, in_ci=0, out_rd=1 -> out_vld high 5 edges after the handshake, out_s=8, out_co=0; busy high through RUN/DONE; in_rd low during RUN.
- in_a=15, in_b=1, in_ci=0 -> out_s=0, out_co=1; with SERIAL_ADDER_CTRL_OVF_EN, out_ovf=0.
- in_a=7, in_b=1, in_ci=0 with SERIAL_ADDER_CTRL_OVF_EN -> out_s=8, out_co=0, out_ovf=1; then in_a=15, in_b=15, in_ci=1 -> out_s=15, out_co=1, out_ovf=0.
- Backpressure: out_rd=0 for 6 cycles in DONE -> out_vld, out_s and out_co stable; out_rd=1 -> IDLE next edge and in_rd=1.
- in_vld held high with new operands 9+4 during RUN of 2+2 -> first result is 4 (in_b=4 not captured); 9+4=13 is accepted only after DONE->IDLE.
- rst_n=0 for 1 cycle at the 2nd RUN cycle -> out_vld=0, busy=0, in_rd=1 next cycle; a subsequent 6+6+1 gives out_s=13, out_co=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller.
// One full adder is reused over DATA_WIDTH cycles, LSB first. The result is
// {out_co, out_s} = in_a + in_b + in_ci.
// Operands come in over a valid/ready pair, and the result leaves over another
// valid/ready pair.
// Optional feature: define SERIAL_ADDER_CTRL_OVF_EN to add the out_ovf port.
// out_ovf is the signed two's-complement overflow of the add.

// Single-bit full adder; the only arithmetic element of the controller.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_ci,
  input  logic                  in_vld,
  output logic                  in_rd,
  output logic [DATA_WIDTH-1:0] out_s,
  output logic                  out_co,
  output logic                  out_vld,
  input  logic                  out_rd,
  output logic                  busy
`ifdef SERIAL_ADDER_CTRL_OVF_EN
  ,
  output logic                  out_ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value on the cycle that processes the MSB.
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t                state;
  logic [DATA_WIDTH-1:0] a_sh;
  logic [DATA_WIDTH-1:0] b_sh;
  logic [DATA_WIDTH-1:0] s_sh;
  logic                  carry;
  logic [CNT_WIDTH-1:0]  cnt;

  logic                  fa_s;
  logic                  fa_co;
  logic [DATA_WIDTH-1:0] s_next;

  // The one shared adder always looks at the current LSBs and the carry flop.
  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // The new sum bit enters at the MSB, and the partial sum moves toward the LSB.
  // On the last bit this value is already the complete sum.
  assign s_next = DATA_WIDTH'({fa_s, s_sh} >> 1'b1);

  // Sequencing FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      in_rd   <= 1'b1;
      out_vld <= 1'b0;
      busy    <= 1'b0;
      out_s   <= '0;
      out_co  <= 1'b0;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
      out_ovf <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_vld) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            carry <= in_ci;
            s_sh  <= '0;
            cnt   <= '0;
            state <= RUN;
            in_rd <= 1'b0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            in_rd <= 1'b1;
            busy  <= 1'b0;
          end
        end

        RUN: begin
          // The operands are consumed LSB first. Zeros fill in from the top.
          a_sh  <= {1'b0, a_sh[DATA_WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[DATA_WIDTH-1:1]};
          s_sh  <= s_next;
          carry <= fa_co;
          if (cnt == LAST_CNT) begin
            // On the MSB cycle, publish the result straight into the output flops.
            // out_vld then rises at the same edge as the transition to DONE.
            // cnt is held here, so it never passes DATA_WIDTH-1.
            cnt     <= cnt;
            state   <= DONE;
            out_vld <= 1'b1;
            out_s   <= s_next;
            out_co  <= fa_co;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
            // carry holds the carry into the MSB, and fa_co is the carry out of it.
            out_ovf <= carry ^ fa_co;
`endif
          end else begin
            cnt   <= cnt + CNT_ONE;
            state <= RUN;
          end
        end

        DONE: begin
          if (out_rd) begin
            // Do not capture new operands on this cycle.
            // in_rd only rises once the FSM is back in IDLE.
            state   <= IDLE;
            out_vld <= 1'b0;
            in_rd   <= 1'b1;
            busy    <= 1'b0;
          end else begin
            state   <= DONE;
            out_vld <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          carry   <= 1'b0;
          in_rd   <= 1'b1;
          out_vld <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl.
// It uses directed cases from the test plan plus randomized operands and
// backpressure. Every expected value comes from plain integer arithmetic
// applied to the operands.
module tb_serial_adder_ctrl;

  localparam int DW = 4;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_ci;
  logic          in_vld;
  logic          in_rd;
  logic [DW-1:0] out_s;
  logic          out_co;
  logic          out_vld;
  logic          out_rd;
  logic          busy;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
  logic          out_ovf;
  logic          last_ovf;
`endif

  int            n_cmp;
  int            n_err;
  logic [DW-1:0] last_s;
  logic          last_co;

  serial_adder_ctrl #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_a    (in_a),
    .in_b    (in_b),
    .in_ci   (in_ci),
    .in_vld  (in_vld),
    .in_rd   (in_rd),
    .out_s   (out_s),
    .out_co  (out_co),
    .out_vld (out_vld),
    .out_rd  (out_rd),
    .busy    (busy)
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    ,
    .out_ovf (out_ovf)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Signed overflow from plain signed integer arithmetic.
  function automatic logic ref_ovf(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic ci);
    int sa;
    int sb;
    int s;
    sa = a[DW-1] ? int'(a) - (1 << DW) : int'(a);
    sb = b[DW-1] ? int'(b) - (1 << DW) : int'(b);
    s  = sa + sb + int'(ci);
    return (s > (1 << (DW - 1)) - 1) || (s < -(1 << (DW - 1)));
  endfunction

  // One complete transaction.
  // hold is the number of DONE cycles with out_rd low.
  // keep leaves in_vld high during RUN with the next operands (na, nb, nci) presented.
  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic ci,
                        input int hold, input bit keep,
                        input logic [DW-1:0] na, input logic [DW-1:0] nb, input logic nci);
    int          n;
    logic [DW:0] exp;
    exp = (DW+1)'(a) + (DW+1)'(b) + (DW+1)'(ci);
    n = 0;
    while (!in_rd && n < 50) begin
      @(negedge clk);
      n = n + 1;
    end
    check_eq("wait_in_rd", 32'(in_rd), 32'd1);
    in_a   = a;
    in_b   = b;
    in_ci  = ci;
    in_vld = 1'b1;
    out_rd = (hold == 0);
    @(negedge clk);
    if (keep) begin
      in_a  = na;
      in_b  = nb;
      in_ci = nci;
    end else begin
      in_vld = 1'b0;
    end
    n = 0;
    while (!out_vld && n < 40) begin
      check_eq("run_in_rd", 32'(in_rd), 32'd0);
      check_eq("run_busy", 32'(busy), 32'd1);
      check_eq("run_hold_s", 32'(out_s), 32'(last_s));
      check_eq("run_hold_co", 32'(out_co), 32'(last_co));
      @(negedge clk);
      n = n + 1;
    end
    check_eq("latency", 32'(n), 32'(DW));
    check_eq("sum", 32'(out_s), 32'(exp[DW-1:0]));
    check_eq("carry_out", 32'(out_co), 32'(exp[DW]));
    check_eq("done_busy", 32'(busy), 32'd1);
    check_eq("done_in_rd", 32'(in_rd), 32'd0);
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    check_eq("ovf", 32'(out_ovf), 32'(ref_ovf(a, b, ci)));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("bp_vld", 32'(out_vld), 32'd1);
      check_eq("bp_s", 32'(out_s), 32'(exp[DW-1:0]));
      check_eq("bp_co", 32'(out_co), 32'(exp[DW]));
    end
    out_rd = 1'b1;
    @(negedge clk);
    check_eq("idle_vld", 32'(out_vld), 32'd0);
    check_eq("idle_in_rd", 32'(in_rd), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_hold_s", 32'(out_s), 32'(exp[DW-1:0]));
    last_s  = exp[DW-1:0];
    last_co = exp[DW];
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    last_s  = '0;
    last_co = 1'b0;
    rst_n   = 1'b0;
    in_a    = '0;
    in_b    = '0;
    in_ci   = 1'b0;
    in_vld  = 1'b0;
    out_rd  = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_rd", 32'(in_rd), 32'd1);
    check_eq("rst_vld", 32'(out_vld), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_s", 32'(out_s), 32'd0);
    check_eq("rst_co", 32'(out_co), 32'd0);
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    check_eq("rst_ovf", 32'(out_ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases from the test plan.
    run_op(4'd3, 4'd5, 1'b0, 0, 1'b0, '0, '0, 1'b0);
    run_op(4'd15, 4'd1, 1'b0, 0, 1'b0, '0, '0, 1'b0);
    run_op(4'd7, 4'd1, 1'b0, 0, 1'b0, '0, '0, 1'b0);
    run_op(4'd15, 4'd15, 1'b1, 0, 1'b0, '0, '0, 1'b0);
    run_op(4'd10, 4'd6, 1'b1, 6, 1'b0, '0, '0, 1'b0);

    // Hold in_vld high with 9+4 during the 2+2 run.
    // The 2+2 result must not be disturbed, and 9+4 follows afterwards.
    run_op(4'd2, 4'd2, 1'b0, 0, 1'b1, 4'd9, 4'd4, 1'b0);
    run_op(4'd9, 4'd4, 1'b0, 0, 1'b0, '0, '0, 1'b0);

    // Reset asserted on the second RUN cycle aborts the add.
    in_a   = 4'd2;
    in_b   = 4'd3;
    in_ci  = 1'b0;
    in_vld = 1'b1;
    out_rd = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort_vld", 32'(out_vld), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_in_rd", 32'(in_rd), 32'd1);
    check_eq("abort_s", 32'(out_s), 32'd0);
    last_s  = '0;
    last_co = 1'b0;
    run_op(4'd6, 4'd6, 1'b1, 0, 1'b0, '0, '0, 1'b0);

    // Randomized operands and backpressure.
    for (int k = 0; k < 40; k++) begin
      run_op(DW'($urandom), DW'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             1'b0, '0, '0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
